// File: rtl/network_frame_loader_if.sv
// Sample stream into the frame loader.
// A sample transfers on a rising edge where s_valid and s_ready are both high; the source holds s_data/s_last stable while s_valid is high and s_ready is low.
interface network_frame_loader_if #(
  parameter int DATA_W = 27
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/network_frame_loader.sv
// Collects N_IN-sample frames into a fill buffer, copies each frame to a stable bank
// and launches the network; the next frame fills while the network computes.
module network_frame_loader #(
  parameter int DATA_W  = 27,
  parameter int N_IN    = 9,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  network_frame_loader_if.slave    stream,
  output logic [N_IN*DATA_W-1:0]   net_in,
  output logic [N_IN-1:0]          net_start,
  input  logic                     net_end,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     timeout_err,
  output logic [CNT_W-1:0]         frames_done,
  output logic [1:0]               state_dbg
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx;
  logic              full;
  logic [DATA_W-1:0] fill_buf [N_IN];
  logic [TMR_W-1:0]  tmr;
  logic              xfer;
  logic              load;
  logic              done_inc;
  logic              tmo_hit;

  // Held low during reset so every output reads 0 while rst is asserted.
  assign stream.s_ready = !full && !rst;
  assign xfer           = stream.s_valid && stream.s_ready;
  assign state_dbg      = state;

  // Sample storage carries no reset; only idx/full decide what is valid.
  always_ff @(posedge clk) begin
    if (xfer) fill_buf[idx] <= stream.s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      full      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (load) full <= 1'b0;
      if (xfer) begin
        if (idx == LAST_IDX && stream.s_last) begin
          full <= 1'b1;
          idx  <= '0;
        end else if (idx == LAST_IDX || stream.s_last) begin
          frame_err <= 1'b1;
          idx       <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    done_inc  = 1'b0;
    tmo_hit   = 1'b0;
    net_start = '0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (full) begin
          load    = 1'b1;
          state_n = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        net_start = '1;
        busy      = 1'b1;
        state_n   = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (net_end) begin
          done_inc = 1'b1;
          if (full) begin
            load    = 1'b1;
            state_n = ST_LAUNCH;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (tmr == TMR_MAX) begin
          tmo_hit = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr         <= '0;
      net_in      <= '0;
      frames_done <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_LAUNCH)    tmr <= '0;
      else if (state == ST_WAIT) tmr <= tmr + TMR_W'(1);
      if (load) begin
        for (int k = 0; k < N_IN; k++) net_in[k*DATA_W +: DATA_W] <= fill_buf[k];
      end
      if (done_inc) frames_done <= frames_done + CNT_W'(1);
      if (tmo_hit)  timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_network_frame_loader.sv
// Directed bench for network_frame_loader: a default-timeout instance plus a
// TIMEOUT=16 instance fed from the same stream and net_end.
module tb_network_frame_loader;
  localparam int DATA_W = 27;
  localparam int N_IN   = 9;
  localparam int CNT_W  = 16;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_LAUNCH = 2'd1, ST_WAIT = 2'd2;
  localparam logic [DATA_W-1:0] MIN_V = 27'h4000000;
  localparam logic [DATA_W-1:0] MAX_V = 27'h3FFFFFF;

  logic clk = 1'b0;
  logic rst;
  logic net_end;
  logic [N_IN*DATA_W-1:0] net_in, net_in_to;
  logic [N_IN-1:0]        net_start, net_start_to;
  logic                   busy, busy_to, frame_err, frame_err_to, timeout_err, timeout_err_to;
  logic [CNT_W-1:0]       frames_done, frames_done_to;
  logic [1:0]             state_dbg, state_dbg_to;

  network_frame_loader_if #(.DATA_W(DATA_W)) sif ();
  network_frame_loader_if #(.DATA_W(DATA_W)) sif_to ();
  assign sif_to.s_data  = sif.s_data;
  assign sif_to.s_valid = sif.s_valid;
  assign sif_to.s_last  = sif.s_last;

  always #5 clk = ~clk;

  network_frame_loader #(.DATA_W(DATA_W), .N_IN(N_IN), .TIMEOUT(1024), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stream(sif), .net_in(net_in), .net_start(net_start),
    .net_end(net_end), .busy(busy), .frame_err(frame_err), .timeout_err(timeout_err),
    .frames_done(frames_done), .state_dbg(state_dbg)
  );

  network_frame_loader #(.DATA_W(DATA_W), .N_IN(N_IN), .TIMEOUT(16), .CNT_W(CNT_W)) dut_to (
    .clk(clk), .rst(rst), .stream(sif_to), .net_in(net_in_to), .net_start(net_start_to),
    .net_end(net_end), .busy(busy_to), .frame_err(frame_err_to), .timeout_err(timeout_err_to),
    .frames_done(frames_done_to), .state_dbg(state_dbg_to)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_done = 0;
  logic [DATA_W-1:0] frame_v [N_IN];

  // ---------------- driver tasks (all start and end on a falling edge) ----------------
  task automatic do_reset();
    rst = 1'b1; net_end = 1'b0;
    sif.s_valid = 1'b0; sif.s_last = 1'b0; sif.s_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_done = 0;
  endtask

  task automatic send_sample(input logic [DATA_W-1:0] d, input logic l);
    int guard;
    guard = 0;
    sif.s_data = d; sif.s_valid = 1'b1; sif.s_last = l;
    while (sif.s_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) begin n_checks++; n_fail++; $display("FAIL send_ready_wait: s_ready=%0b, required 1", sif.s_ready); end
    @(negedge clk);
  endtask

  task automatic send_frame(input int n, input int last_at);
    for (int k = 0; k < n; k++) send_sample(frame_v[k], k == last_at);
    sif.s_valid = 1'b0; sif.s_last = 1'b0;
  endtask

  task automatic set_frame(input int base);
    for (int k = 0; k < N_IN; k++) frame_v[k] = DATA_W'(base + k);
  endtask

  task automatic wait_launch(output int lat);
    lat = 0;
    while (net_start !== {N_IN{1'b1}} && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic pulse_end(input int n);
    repeat (n) @(negedge clk);
    net_end = 1'b1;
    @(negedge clk);
    net_end = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; net_end = 1'b0; sif.s_valid = 1'b0; sif.s_last = 1'b0; sif.s_data = '0;
    #1;
    n_checks++; if (sif.s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready_during: got %0b required 0", sif.s_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d required %0d", state_dbg, ST_IDLE); end
    n_checks++; if (net_in !== '0) begin n_fail++; $display("FAIL rst_net_in: got %h required 0", net_in); end
    n_checks++; if ({net_start, busy, frame_err, timeout_err} !== '0) begin n_fail++; $display("FAIL rst_ctrl: got %b required 0", {net_start, busy, frame_err, timeout_err}); end
    n_checks++; if (frames_done !== '0) begin n_fail++; $display("FAIL rst_frames_done: got %0d required 0", frames_done); end
    n_checks++; if (sif.s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready_after: got %0b required 1", sif.s_ready); end
  endtask

  task automatic test_single_frame();
    int lat, busy_cnt, start_cnt;
    set_frame(1);
    send_frame(N_IN, N_IN - 1);
    n_checks++; if (sif.s_ready !== 1'b0) begin n_fail++; $display("FAIL t1_full_ready: got %0b required 0", sif.s_ready); end
    wait_launch(lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL t1_launch_latency: got %0d required 1", lat); end
    for (int k = 0; k < N_IN; k++) begin
      n_checks++; if (net_in[k*DATA_W +: DATA_W] !== DATA_W'(k + 1)) begin n_fail++; $display("FAIL t1_net_in[%0d]: got %0d required %0d", k, net_in[k*DATA_W +: DATA_W], k + 1); end
    end
    busy_cnt = 0; start_cnt = 0;
    for (int i = 0; i <= 20; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (net_start === {N_IN{1'b1}}) start_cnt++;
      if (i == 20) net_end = 1'b1;
      @(negedge clk);
    end
    net_end = 1'b0; exp_done++;
    n_checks++; if (busy_cnt !== 21) begin n_fail++; $display("FAIL t1_busy_cycles: got %0d required 21", busy_cnt); end
    n_checks++; if (start_cnt !== 1) begin n_fail++; $display("FAIL t1_start_cycles: got %0d required 1", start_cnt); end
    n_checks++; if (busy !== 1'b0 || state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL t1_idle_after: busy=%0b state=%0d required 0/0", busy, state_dbg); end
    n_checks++; if (frames_done !== CNT_W'(exp_done)) begin n_fail++; $display("FAIL t1_frames_done: got %0d required %0d", frames_done, exp_done); end
  endtask

  task automatic test_back_to_back();
    int lat;
    set_frame(10);
    send_frame(N_IN, N_IN - 1);
    wait_launch(lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL t2_launch_a: got %0d required 1", lat); end
    @(negedge clk);
    set_frame(100);
    send_frame(N_IN, N_IN - 1);
    n_checks++; if (sif.s_ready !== 1'b0) begin n_fail++; $display("FAIL t2_ready_drop: got %0b required 0", sif.s_ready); end
    n_checks++; if (state_dbg !== ST_WAIT || net_start !== '0) begin n_fail++; $display("FAIL t2_still_wait: state=%0d start=%h required 2/0", state_dbg, net_start); end
    for (int k = 0; k < N_IN; k++) begin
      n_checks++; if (net_in[k*DATA_W +: DATA_W] !== DATA_W'(10 + k)) begin n_fail++; $display("FAIL t2_bank_a[%0d]: got %0d required %0d", k, net_in[k*DATA_W +: DATA_W], 10 + k); end
    end
    net_end = 1'b1;
    @(negedge clk);
    net_end = 1'b0; exp_done++;
    n_checks++; if (net_start !== {N_IN{1'b1}}) begin n_fail++; $display("FAIL t2_relaunch: got %h required 1ff", net_start); end
    n_checks++; if (frames_done !== CNT_W'(exp_done)) begin n_fail++; $display("FAIL t2_frames_done_a: got %0d required %0d", frames_done, exp_done); end
    n_checks++; if (sif.s_ready !== 1'b1) begin n_fail++; $display("FAIL t2_ready_back: got %0b required 1", sif.s_ready); end
    for (int k = 0; k < N_IN; k++) begin
      n_checks++; if (net_in[k*DATA_W +: DATA_W] !== DATA_W'(100 + k)) begin n_fail++; $display("FAIL t2_bank_b[%0d]: got %0d required %0d", k, net_in[k*DATA_W +: DATA_W], 100 + k); end
    end
    pulse_end(3); exp_done++;
    n_checks++; if (frames_done !== CNT_W'(exp_done) || state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL t2_done_b: frames=%0d state=%0d required %0d/0", frames_done, state_dbg, exp_done); end
  endtask

  task automatic test_frame_err();
    int lat, starts;
    set_frame(50);
    send_frame(5, 4);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL t3_err_short: got %0b required 1", frame_err); end
    n_checks++; if (sif.s_ready !== 1'b1 || state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL t3_no_full: ready=%0b state=%0d required 1/0", sif.s_ready, state_dbg); end
    @(negedge clk);
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL t3_err_pulse: got %0b required 0", frame_err); end
    send_frame(N_IN, 99);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL t3_err_no_last: got %0b required 1", frame_err); end
    starts = 0;
    repeat (10) begin if (net_start !== '0 || busy !== 1'b0) starts++; @(negedge clk); end
    n_checks++; if (starts !== 0) begin n_fail++; $display("FAIL t3_no_launch: got %0d active cycles required 0", starts); end
    set_frame(200);
    send_frame(N_IN, N_IN - 1);
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL t3_good_no_err: got %0b required 0", frame_err); end
    wait_launch(lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL t3_launch: got %0d required 1", lat); end
    for (int k = 0; k < N_IN; k++) begin
      n_checks++; if (net_in[k*DATA_W +: DATA_W] !== DATA_W'(200 + k)) begin n_fail++; $display("FAIL t3_net_in[%0d]: got %0d required %0d", k, net_in[k*DATA_W +: DATA_W], 200 + k); end
    end
    pulse_end(2); exp_done++;
    n_checks++; if (frames_done !== CNT_W'(exp_done)) begin n_fail++; $display("FAIL t3_frames_done: got %0d required %0d", frames_done, exp_done); end
  endtask

  task automatic test_extremes();
    int lat;
    for (int k = 0; k < N_IN; k++) frame_v[k] = (k % 2 == 0) ? MIN_V : MAX_V;
    send_frame(N_IN, N_IN - 1);
    wait_launch(lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL t4_launch: got %0d required 1", lat); end
    for (int k = 0; k < N_IN; k++) begin
      n_checks++; if (net_in[k*DATA_W +: DATA_W] !== ((k % 2 == 0) ? MIN_V : MAX_V)) begin n_fail++; $display("FAIL t4_value[%0d]: got %h required %h", k, net_in[k*DATA_W +: DATA_W], (k % 2 == 0) ? MIN_V : MAX_V); end
      n_checks++; if (($signed(net_in[k*DATA_W +: DATA_W]) < 0) !== (k % 2 == 0)) begin n_fail++; $display("FAIL t4_sign[%0d]: negative=%0b required %0b", k, $signed(net_in[k*DATA_W +: DATA_W]) < 0, k % 2 == 0); end
    end
    pulse_end(1); exp_done++;
    n_checks++; if (frames_done !== CNT_W'(exp_done)) begin n_fail++; $display("FAIL t4_frames_done: got %0d required %0d", frames_done, exp_done); end
  endtask

  task automatic test_timeout();
    int lat;
    do_reset();
    set_frame(300);
    send_frame(N_IN, N_IN - 1);
    wait_launch(lat);
    n_checks++; if (net_start_to !== {N_IN{1'b1}} || lat !== 1) begin n_fail++; $display("FAIL t5_launch: start=%h lat=%0d required 1ff/1", net_start_to, lat); end
    repeat (16) @(negedge clk);
    n_checks++; if (timeout_err_to !== 1'b0 || state_dbg_to !== ST_WAIT) begin n_fail++; $display("FAIL t5_before: err=%0b state=%0d required 0/2", timeout_err_to, state_dbg_to); end
    @(negedge clk);
    n_checks++; if (timeout_err_to !== 1'b1) begin n_fail++; $display("FAIL t5_timeout_err: got %0b required 1", timeout_err_to); end
    n_checks++; if (state_dbg_to !== ST_IDLE || busy_to !== 1'b0) begin n_fail++; $display("FAIL t5_idle: state=%0d busy=%0b required 0/0", state_dbg_to, busy_to); end
    n_checks++; if (frames_done_to !== '0) begin n_fail++; $display("FAIL t5_frames_done: got %0d required 0", frames_done_to); end
    n_checks++; if (net_in_to[8*DATA_W +: DATA_W] !== DATA_W'(308)) begin n_fail++; $display("FAIL t5_bank_kept: got %0d required 308", net_in_to[8*DATA_W +: DATA_W]); end
    pulse_end(3);
    n_checks++; if (timeout_err_to !== 1'b1 || frames_done_to !== '0) begin n_fail++; $display("FAIL t5_sticky: err=%0b frames=%0d required 1/0", timeout_err_to, frames_done_to); end
  endtask

  task automatic test_async_reset();
    int lat, starts;
    do_reset();
    set_frame(400);
    send_frame(N_IN, N_IN - 1);
    wait_launch(lat);
    pulse_end(2);
    n_checks++; if (frames_done !== CNT_W'(1)) begin n_fail++; $display("FAIL t6_pre_done: got %0d required 1", frames_done); end
    set_frame(500);
    send_frame(N_IN, N_IN - 1);
    wait_launch(lat);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({net_start, busy, frame_err, timeout_err, sif.s_ready} !== '0) begin n_fail++; $display("FAIL t6_wait_ctrl: got %b required 0", {net_start, busy, frame_err, timeout_err, sif.s_ready}); end
    n_checks++; if (net_in !== '0 || frames_done !== '0 || state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL t6_wait_regs: net_in=%h frames=%0d state=%0d required 0", net_in, frames_done, state_dbg); end
    @(negedge clk); rst = 1'b0; @(negedge clk);
    set_frame(600);
    send_frame(4, 99);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (sif.s_ready !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL t6_fill_ctrl: ready=%0b err=%0b required 0/0", sif.s_ready, frame_err); end
    @(negedge clk); rst = 1'b0; @(negedge clk);
    set_frame(700);
    send_frame(5, 4);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL t6_partial_lost: err=%0b required 1", frame_err); end
    starts = 0;
    repeat (5) begin if (net_start !== '0) starts++; @(negedge clk); end
    n_checks++; if (starts !== 0) begin n_fail++; $display("FAIL t6_no_launch: got %0d required 0", starts); end
    set_frame(800);
    send_frame(N_IN, N_IN - 1);
    wait_launch(lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL t6_fresh_launch: got %0d required 1", lat); end
    n_checks++; if (net_in[0 +: DATA_W] !== DATA_W'(800) || net_in[8*DATA_W +: DATA_W] !== DATA_W'(808)) begin n_fail++; $display("FAIL t6_fresh_bank: k0=%0d k8=%0d required 800/808", net_in[0 +: DATA_W], net_in[8*DATA_W +: DATA_W]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_frame_err();
    test_extremes();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
